// File: rtl/umi_arbiter_if.sv
// umi_arbiter_if: request/grant handshake bundle between requesters, arbiter and downstream mux.
interface umi_arbiter_if #(
    parameter int N = 4
);
    logic         mode;
    logic [N-1:0] mask;
    logic [N-1:0] umi_in_valid;
    logic [N-1:0] umi_in_ready;
    logic         umi_out_ready;
    logic         umi_out_valid;
    logic [N-1:0] grant;
    modport master (
        output mode, mask, umi_in_valid, umi_out_ready,
        input  umi_in_ready, umi_out_valid, grant
    );
    modport slave (
        input  mode, mask, umi_in_valid, umi_out_ready,
        output umi_in_ready, umi_out_valid, grant
    );
endinterface

// File: rtl/umi_arbiter.sv
// umi_arbiter: round-robin / fixed-priority arbiter producing a one-hot mux select,
// holding the grant until the downstream handshake completes.
module umi_arbiter #(
    parameter int N = 4
) (
    input  logic        clk,
    input  logic        reset,
    umi_arbiter_if.slave bus
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t       state_q, state_d;
    logic [N-1:0] lock_q, lock_d;
    logic [N-1:0] last_q, last_d;
    logic [N-1:0] req, thermo, rr_hi, rr, arb, grant;
    logic         hit, xfer;
    function automatic logic [N-1:0] lowest(input logic [N-1:0] v);
        return v & (~v + 1'b1);
    endfunction
    always_comb begin
        req = bus.umi_in_valid & ~bus.mask;
        hit = 1'b0;
        thermo = '0;
        // thermo covers indices at or below the last winner, so the first pass starts just above it
        for (int i = N - 1; i >= 0; i--) begin
            hit = hit | last_q[i];
            thermo[i] = hit;
        end
        rr_hi = lowest(req & ~thermo);
        rr = (rr_hi != '0) ? rr_hi : lowest(req);
        arb = bus.mode ? lowest(req) : rr;
        grant = reset ? '0 : (state_q == LOCKED) ? (lock_q & bus.umi_in_valid) : arb;
        xfer = (grant != '0) & bus.umi_out_ready;
        state_d = (state_q == IDLE) ? (((grant != '0) && !xfer) ? LOCKED : IDLE)
                                    : ((xfer || grant == '0) ? IDLE : LOCKED);
        lock_d = ((state_q == IDLE) && (grant != '0) && !xfer) ? grant : lock_q;
        last_d = xfer ? grant : last_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lock_q  <= '0;
            last_q  <= N'(1) << (N - 1);
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            last_q  <= last_d;
        end
    end
    assign bus.grant         = grant;
    assign bus.umi_out_valid = |grant;
    assign bus.umi_in_ready  = grant & {N{bus.umi_out_ready}};
endmodule
